// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches one word at a time, and follows branch-unit redirects or traps.
// Optional build macro FETCH_STAGE_MISALIGN_TRAP_EN: trap (cause 2) on a misaligned redirect instead of aligning it.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_error,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_pc,
  input  logic        trap_clear
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT_RSP,
    S_HOLD,
    S_WAIT_NEXT,
    S_TRAP
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_req_valid;
  logic        r_instr_valid;
  logic [31:0] r_instr_data;
  logic [31:0] r_instr_pc;
  logic        r_trap;
  logic [1:0]  r_trap_cause;
  logic [31:0] r_trap_pc;

  logic        w_misaligned;
  logic [31:0] w_next_pc;

`ifdef FETCH_STAGE_MISALIGN_TRAP_EN
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_next_pc    = redirect_pc;
`else
  assign w_misaligned = 1'b0;
  assign w_next_pc    = redirect_pc & ~32'h0000_0003;
`endif

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr_data  <= '0;
      r_instr_pc    <= '0;
      r_trap        <= 1'b0;
      r_trap_cause  <= '0;
      r_trap_pc     <= '0;
    end else begin
      case (r_state)
        // Request valid comes up one cycle after reset; other REQ entries raise it directly.
        S_REQ: begin
          if (r_req_valid && mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WAIT_RSP;
          end else begin
            r_req_valid <= 1'b1;
          end
        end
        S_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            r_instr_data  <= mem_rsp_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_WAIT_NEXT;
          end
        end
        S_WAIT_NEXT: begin
          if (redirect_valid) begin
            if (redirect_error) begin
              r_trap       <= 1'b1;
              r_trap_cause <= 2'd1;
              r_trap_pc    <= r_pc;
              r_state      <= S_TRAP;
            end else if (w_misaligned) begin
              r_trap       <= 1'b1;
              r_trap_cause <= 2'd2;
              r_trap_pc    <= redirect_pc;
              r_state      <= S_TRAP;
            end else begin
              r_pc        <= w_next_pc;
              r_req_valid <= 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
        S_TRAP: begin
          if (trap_clear) begin
            r_pc         <= RESET_PC;
            r_trap       <= 1'b0;
            r_trap_cause <= '0;
            r_trap_pc    <= '0;
            r_req_valid  <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        default: begin
          r_state     <= S_REQ;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_pc;
  assign instr_valid   = r_instr_valid;
  assign instr_data    = r_instr_data;
  assign instr_pc      = r_instr_pc;
  assign trap          = r_trap;
  assign trap_cause    = r_trap_cause;
  assign trap_pc       = r_trap_pc;

endmodule
